// File: rtl/oser10_pkg.sv
// Shared types and constants for the OSER10 word feeder.
// Holds the bring-up state enum, default words and the PRBS7 helper.
package oser10_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        TRAIN = 2'd1,
        DATA  = 2'd2
    } state_e;

    localparam logic [9:0] IDLE_WORD_DEF  = 10'b1010101010;
    localparam logic [9:0] TRAIN_WORD_DEF = 10'b0000011111;

    localparam logic [6:0] PRBS7_SEED = 7'h7F;
    localparam logic [6:0] PRBS7_TAPS = 7'b1100000;

    // Returns {next_lfsr, word}; word[0] is the first bit generated.
    function automatic logic [16:0] prbs7_step10(input logic [6:0] s);
        logic [6:0] v;
        logic [9:0] w;
        logic       b;
        v = s;
        w = '0;
        for (int i = 0; i < 10; i++) begin
            b    = ^(v & PRBS7_TAPS);
            w[i] = b;
            v    = {v[5:0], b};
        end
        return {v, w};
    endfunction

endpackage

// File: rtl/oser10_word_fifo.sv
// Synchronous word FIFO with async active-low reset and flush.
// Power-of-two depth; pointers wrap naturally, count is one bit wider.
module oser10_word_fifo
#(
    parameter int DEPTH = 8,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign rdata  = r_mem[r_rptr];
    assign w_push = push && !full && !flush;
    assign w_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/oser10_word_feeder.sv
// Word source for an OSER10: reset hold, training, then buffered data.
// Define OSER10_FEEDER_PRBS_EN to replace DATA idle words with PRBS7.
module oser10_word_feeder
    import oser10_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 8,
    parameter int         WARMUP_CYC  = 4,
    parameter int         TRAIN_WORDS = 16,
    parameter logic [9:0] TRAIN_WORD  = TRAIN_WORD_DEF,
    parameter logic [9:0] IDLE_WORD   = IDLE_WORD_DEF
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic       restart,
    input  logic [9:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [9:0] d,
    output logic       oser_reset,
    output logic       link_up,
    output logic [7:0] underflow_cnt
);

    localparam int CMAX = (TRAIN_WORDS > WARMUP_CYC) ? TRAIN_WORDS : WARMUP_CYC;
    localparam int CW   = $clog2(CMAX) + 1;

    localparam logic [CW-1:0] WARM_LAST  = CW'(WARMUP_CYC - 1);
    localparam logic [CW-1:0] TRAIN_LAST = CW'(TRAIN_WORDS - 1);

    state_e        r_state;
    logic [CW-1:0] r_cnt;
    logic [9:0]    r_d;
    logic          r_oser_reset;
    logic          r_link_up;
    logic [7:0]    r_ucnt;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_emit;
    logic [9:0]    w_head;
    logic [9:0]    w_idle;

    // w_emit marks every edge that produces a DATA word, including the
    // TRAIN->DATA edge, so link_up rises together with the first one.
    assign w_emit   = !restart && ((r_state == DATA) ||
                      (r_state == TRAIN && r_cnt == TRAIN_LAST));
    assign in_ready = (r_state != HOLD) && !w_full;
    assign w_push   = in_valid && in_ready && !restart;
    assign w_pop    = w_emit && !w_empty;

    assign d             = r_d;
    assign oser_reset    = r_oser_reset;
    assign link_up       = r_link_up;
    assign underflow_cnt = r_ucnt;

    oser10_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (10)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_i),
        .flush (restart),
        .push  (w_push),
        .wdata (in_data),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

`ifdef OSER10_FEEDER_PRBS_EN
    logic [6:0]  r_lfsr;
    logic [16:0] w_prbs;

    assign w_prbs = prbs7_step10(r_lfsr);
    assign w_idle = w_prbs[9:0];

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            r_lfsr <= PRBS7_SEED;
        end else if (restart) begin
            r_lfsr <= PRBS7_SEED;
        end else if (w_emit && w_empty) begin
            r_lfsr <= w_prbs[16:10];
        end
    end
`else
    assign w_idle = IDLE_WORD;
`endif

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= HOLD;
            r_cnt        <= '0;
            r_d          <= IDLE_WORD;
            r_oser_reset <= 1'b1;
            r_link_up    <= 1'b0;
            r_ucnt       <= '0;
        end else if (restart) begin
            r_state      <= HOLD;
            r_cnt        <= '0;
            r_d          <= IDLE_WORD;
            r_oser_reset <= 1'b1;
            r_link_up    <= 1'b0;
        end else begin
            unique case (r_state)
                HOLD: begin
                    r_d          <= IDLE_WORD;
                    r_oser_reset <= 1'b1;
                    if (r_cnt == WARM_LAST) begin
                        r_state      <= TRAIN;
                        r_cnt        <= '0;
                        r_d          <= TRAIN_WORD;
                        r_oser_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                TRAIN: begin
                    r_oser_reset <= 1'b0;
                    if (r_cnt == TRAIN_LAST) begin
                        r_state   <= DATA;
                        r_cnt     <= '0;
                        r_link_up <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        r_d   <= TRAIN_WORD;
                    end
                end
                DATA: begin
                    r_oser_reset <= 1'b0;
                end
                default: begin
                    r_state <= HOLD;
                end
            endcase
            if (w_emit) begin
                r_d <= w_empty ? w_idle : w_head;
                if (w_empty && r_ucnt != 8'hFF) begin
                    r_ucnt <= r_ucnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_oser10_word_feeder.sv
// Directed bench for oser10_word_feeder (default build, no PRBS).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_oser10_word_feeder;

    localparam logic [9:0] IDLE = 10'b1010101010;
    localparam logic [9:0] TRN  = 10'b0000011111;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       restart = 1'b0;
    logic       in_valid = 1'b0;
    logic [9:0] in_data = '0;
    logic       in_ready;
    logic [9:0] d;
    logic       oser_reset;
    logic       link_up;
    logic [7:0] underflow_cnt;

    int         checks = 0;
    int         passed = 0;
    logic [9:0] pre_q[$];
    logic       last_train_ready;

    always #5 clk = ~clk;

    oser10_word_feeder dut (
        .clk           (clk),
        .rst_i         (rst_i),
        .restart       (restart),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .d             (d),
        .oser_reset    (oser_reset),
        .link_up       (link_up),
        .underflow_cnt (underflow_cnt)
    );

    task automatic drive_in();
        if (pre_q.size() > 0) begin
            in_valid = 1'b1;
            in_data  = pre_q[0];
        end else begin
            in_valid = 1'b0;
            in_data  = '0;
        end
    endtask

    task automatic step();
        logic acc;
        acc = in_valid && in_ready && !restart;
        @(posedge clk);
        #1;
        if (acc) void'(pre_q.pop_front());
        drive_in();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_i = 1'b0;
        @(posedge clk);
        #1 rst_i = 1'b1;
    endtask

    // Walks HOLD and TRAIN from the first HOLD cycle; ends on first DATA word.
    task automatic bringup(input string tag);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (oser_reset !== 1'b1 || d !== IDLE || link_up !== 1'b0 ||
                in_ready !== 1'b0)
                $display("FAIL %s_hold%0d: oser=%b d=%h link=%b rdy=%b, want 1 %h 0 0",
                         tag, c, oser_reset, d, link_up, in_ready, IDLE);
            else passed++;
            step();
        end
        for (int t = 0; t < 16; t++) begin
            checks++;
            if (oser_reset !== 1'b0 || d !== TRN || link_up !== 1'b0)
                $display("FAIL %s_train%0d: oser=%b d=%h link=%b, want 0 %h 0",
                         tag, t, oser_reset, d, link_up, TRN);
            else passed++;
            last_train_ready = in_ready;
            step();
        end
    endtask

    task automatic test_reset();
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if (d !== IDLE || oser_reset !== 1'b1 || in_ready !== 1'b0 ||
            link_up !== 1'b0 || underflow_cnt !== 8'd0)
            $display("FAIL reset_async: d=%h oser=%b rdy=%b link=%b ucnt=%0d, want %h 1 0 0 0",
                     d, oser_reset, in_ready, link_up, underflow_cnt, IDLE);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (d !== IDLE || oser_reset !== 1'b1 || link_up !== 1'b0)
            $display("FAIL reset_held: d=%h oser=%b link=%b, want %h 1 0",
                     d, oser_reset, link_up, IDLE);
        else passed++;
        rst_i = 1'b1;
    endtask

    task automatic test_bringup_idle();
        bringup("boot");
        for (int i = 0; i < 300; i++) begin
            int exp;
            exp = (i + 1 > 255) ? 255 : i + 1;
            checks++;
            if (d !== IDLE || link_up !== 1'b1 || oser_reset !== 1'b0 ||
                underflow_cnt !== 8'(exp))
                $display("FAIL idle_data%0d: d=%h link=%b oser=%b ucnt=%0d, want %h 1 0 %0d",
                         i, d, link_up, oser_reset, underflow_cnt, IDLE, exp);
            else passed++;
            step();
        end
    endtask

    task automatic test_prefill();
        logic [9:0] exp_w [5];
        int         exp_u [5];
        exp_w = '{10'h001, 10'h155, 10'h3FF, IDLE, IDLE};
        exp_u = '{0, 0, 0, 1, 2};
        do_reset();
        pre_q = '{10'h001, 10'h155, 10'h3FF};
        drive_in();
        bringup("pre");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            checks++;
            if (d !== exp_w[i] || underflow_cnt !== 8'(exp_u[i]) || link_up !== 1'b1)
                $display("FAIL prefill%0d: d=%h ucnt=%0d link=%b, want %h %0d 1",
                         i, d, underflow_cnt, link_up, exp_w[i], exp_u[i]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 40; k++) pre_q.push_back(10'(k));
        drive_in();
        step();
        checks++;
        if (d !== IDLE || underflow_cnt !== 8'd3)
            $display("FAIL b2b_lat: d=%h ucnt=%0d, want %h 3", d, underflow_cnt, IDLE);
        else passed++;
        for (int n = 0; n < 40; n++) begin
            step();
            checks++;
            if (d !== 10'(n) || in_ready !== 1'b1 || underflow_cnt !== 8'd3)
                $display("FAIL b2b_word%0d: d=%h rdy=%b ucnt=%0d, want %h 1 3",
                         n, d, in_ready, underflow_cnt, 10'(n));
            else passed++;
        end
        step();
        checks++;
        if (d !== IDLE || underflow_cnt !== 8'd4)
            $display("FAIL b2b_end: d=%h ucnt=%0d, want %h 4", d, underflow_cnt, IDLE);
        else passed++;
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 9; k++) pre_q.push_back(10'h100 + 10'(k));
        drive_in();
        bringup("full");
        checks++;
        if (last_train_ready !== 1'b0 || pre_q.size() != 1)
            $display("FAIL full_block: rdy=%b left=%0d, want 0 1",
                     last_train_ready, pre_q.size());
        else passed++;
        checks++;
        if (d !== 10'h100 || in_ready !== 1'b1)
            $display("FAIL full_first: d=%h rdy=%b, want 100 1", d, in_ready);
        else passed++;
        for (int k = 1; k < 9; k++) begin
            step();
            checks++;
            if (d !== 10'h100 + 10'(k))
                $display("FAIL full_word%0d: d=%h, want %h", k, d, 10'h100 + 10'(k));
            else passed++;
        end
        step();
        checks++;
        if (d !== IDLE)
            $display("FAIL full_end: d=%h, want %h", d, IDLE);
        else passed++;
    endtask

    task automatic test_restart();
        do_reset();
        drive_in();
        bringup("rs0");
        for (int i = 0; i < 9; i++) step();
        checks++;
        if (d !== IDLE || underflow_cnt !== 8'd10)
            $display("FAIL rs_pre: d=%h ucnt=%0d, want %h 10", d, underflow_cnt, IDLE);
        else passed++;
        restart = 1'b1;
        step();
        restart = 1'b0;
        checks++;
        if (oser_reset !== 1'b1 || link_up !== 1'b0 || d !== IDLE ||
            underflow_cnt !== 8'd10 || in_ready !== 1'b0)
            $display("FAIL rs_first: oser=%b link=%b d=%h ucnt=%0d rdy=%b, want 1 0 %h 10 0",
                     oser_reset, link_up, d, underflow_cnt, in_ready, IDLE);
        else passed++;
        for (int k = 0; k < 6; k++) pre_q.push_back(10'h0A0 + 10'(k));
        drive_in();
        bringup("rs1");
        checks++;
        if (d !== 10'h0A0 || underflow_cnt !== 8'd10 || link_up !== 1'b1)
            $display("FAIL rs_fill: d=%h ucnt=%0d link=%b, want 0a0 10 1",
                     d, underflow_cnt, link_up);
        else passed++;
        pre_q.push_back(10'h0AF);
        drive_in();
        restart = 1'b1;
        step();
        restart = 1'b0;
        pre_q.delete();
        drive_in();
        checks++;
        if (oser_reset !== 1'b1 || link_up !== 1'b0 || d !== IDLE ||
            underflow_cnt !== 8'd10)
            $display("FAIL rs_second: oser=%b link=%b d=%h ucnt=%0d, want 1 0 %h 10",
                     oser_reset, link_up, d, underflow_cnt, IDLE);
        else passed++;
        bringup("rs2");
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            checks++;
            if (d !== IDLE || link_up !== 1'b1 || underflow_cnt !== 8'(11 + i))
                $display("FAIL rs_flushed%0d: d=%h link=%b ucnt=%0d, want %h 1 %0d",
                         i, d, link_up, underflow_cnt, IDLE, 11 + i);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if (d !== IDLE || oser_reset !== 1'b1 || in_ready !== 1'b0 ||
            link_up !== 1'b0 || underflow_cnt !== 8'd0)
            $display("FAIL mid_reset: d=%h oser=%b rdy=%b link=%b ucnt=%0d, want %h 1 0 0 0",
                     d, oser_reset, in_ready, link_up, underflow_cnt, IDLE);
        else passed++;
        #1 rst_i = 1'b1;
        bringup("ar");
        checks++;
        if (d !== IDLE || link_up !== 1'b1 || underflow_cnt !== 8'd1)
            $display("FAIL ar_data: d=%h link=%b ucnt=%0d, want %h 1 1",
                     d, link_up, underflow_cnt, IDLE);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_bringup_idle();
        test_prefill();
        test_back_to_back();
        test_full();
        test_restart();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
